// File: rtl/keypad_pkg.sv
// Shared types, key codes and helpers for the keypad entry block.
// Optional auto-repeat is built when KEYPAD_AUTO_REPEAT_EN is defined.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   localparam logic [3:0] KEY_SIGN  = 4'hA;
   localparam logic [3:0] KEY_BKSP  = 4'hB;
   localparam logic [3:0] KEY_CLR   = 4'hC;
   localparam logic [3:0] KEY_ENTER = 4'hD;

   localparam int unsigned DEBOUNCE_MS_DEF = 20;

   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'h0:    code = 4'h1;
         4'h1:    code = 4'h2;
         4'h2:    code = 4'h3;
         4'h3:    code = KEY_SIGN;
         4'h4:    code = 4'h4;
         4'h5:    code = 4'h5;
         4'h6:    code = 4'h6;
         4'h7:    code = KEY_BKSP;
         4'h8:    code = 4'h7;
         4'h9:    code = 4'h8;
         4'hA:    code = 4'h9;
         4'hB:    code = KEY_CLR;
         4'hC:    code = 4'hE;
         4'hD:    code = 4'h0;
         4'hE:    code = 4'hF;
         default: code = KEY_ENTER;
      endcase
      return code;
   endfunction

   // Lowest row index wins when several rows read low together.
   function automatic logic [1:0] lowest_row(input logic [3:0] rows);
      if (!rows[0])      return 2'd0;
      else if (!rows[1]) return 2'd1;
      else if (!rows[2]) return 2'd2;
      else               return 2'd3;
   endfunction

   function automatic logic [3:0] col_drive(input logic [1:0] col);
      return ~(4'b1000 >> col);
   endfunction

endpackage

// File: rtl/keypad_bcd_editor.sv
// Signed 3-digit BCD accumulator: applies one key edit per strobe.
module keypad_bcd_editor
   import keypad_pkg::*;
(
   input  logic       clk_1k,
   input  logic       resetn,
   input  logic       stb,
   input  logic [3:0] code,
   output logic       sign,
   output logic [3:0] hundreds,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   logic       nxt_sign;
   logic [3:0] nxt_h, nxt_t, nxt_o;
   logic       nonzero;

   assign nonzero = |{hundreds, tens, ones};

   always_comb begin
      nxt_sign = sign;
      nxt_h    = hundreds;
      nxt_t    = tens;
      nxt_o    = ones;
      if (stb) begin
         if (code <= 4'd9) begin
            if (hundreds == 4'd0) begin
               nxt_h = tens;
               nxt_t = ones;
               nxt_o = code;
            end
         end else begin
            case (code)
               KEY_SIGN: if (nonzero) nxt_sign = ~sign;
               KEY_BKSP: begin
                  nxt_o = tens;
                  nxt_t = hundreds;
                  nxt_h = 4'd0;
                  // a zero value is never shown as negative
                  if (tens == 4'd0 && hundreds == 4'd0) nxt_sign = 1'b0;
               end
               KEY_CLR: begin
                  nxt_sign = 1'b0;
                  nxt_h    = 4'd0;
                  nxt_t    = 4'd0;
                  nxt_o    = 4'd0;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_1k or negedge resetn) begin
      if (!resetn) begin
         sign     <= 1'b0;
         hundreds <= '0;
         tens     <= '0;
         ones     <= '0;
      end else begin
         sign     <= nxt_sign;
         hundreds <= nxt_h;
         tens     <= nxt_t;
         ones     <= nxt_o;
      end
   end

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with debounce feeding a signed 3-digit BCD editor.
// Auto-repeat on held keys is built when KEYPAD_AUTO_REPEAT_EN is defined.
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEF
`ifdef KEYPAD_AUTO_REPEAT_EN
   ,
   parameter int unsigned REPEAT_DELAY = 500,
   parameter int unsigned REPEAT_RATE  = 100
`endif
)(
   input  logic       clk_1k,
   input  logic       resetn,
   input  logic [3:0] key_row,
   output logic [3:0] key_col,
   output logic       sign,
   output logic [3:0] hundreds,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       entry_done
);

   localparam int unsigned CW = $clog2(DEBOUNCE_MS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

   state_t        state;
   logic [1:0]    col_idx;
   logic [1:0]    row_idx;
   logic [3:0]    pend_code;
   logic [CW-1:0] cnt;
   logic          edit_stb;
   logic          rep_fire;

`ifdef KEYPAD_AUTO_REPEAT_EN
   localparam int unsigned HW = $clog2(REPEAT_DELAY + 1);
   localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_DELAY - 1);
   localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_RATE);

   logic [HW-1:0] hold_cnt;
   logic          held_low;
   logic          repeat_ok;

   assign held_low  = (state == RELEASE_WAIT) && (key_row != 4'hF);
   // Enter never repeats; a digit that would overflow is not re-issued.
   assign repeat_ok = (pend_code != KEY_ENTER) &&
                      !((pend_code <= 4'd9) && (hundreds != 4'd0));
   assign rep_fire  = held_low && (hold_cnt == HOLD_LAST) && repeat_ok;

   always_ff @(posedge clk_1k or negedge resetn) begin
      if (!resetn) begin
         hold_cnt <= '0;
      end else if (held_low) begin
         if (hold_cnt == HOLD_LAST) hold_cnt <= HOLD_RELOAD;
         else                       hold_cnt <= hold_cnt + 1'b1;
      end else begin
         hold_cnt <= '0;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   assign edit_stb = (state == PRESSED) || rep_fire;

   always_ff @(posedge clk_1k or negedge resetn) begin
      if (!resetn) begin
         state      <= SCAN;
         col_idx    <= '0;
         row_idx    <= '0;
         pend_code  <= '0;
         cnt        <= '0;
         key_col    <= '1;
         key_code   <= '0;
         key_valid  <= 1'b0;
         entry_done <= 1'b0;
      end else begin
         key_valid  <= edit_stb;
         entry_done <= edit_stb && (pend_code == KEY_ENTER);
         if (edit_stb) key_code <= pend_code;

         case (state)
            SCAN: begin
               // first cycle out of reset only starts driving column 0
               if (key_col == 4'hF) begin
                  key_col <= col_drive(col_idx);
               end else if (key_row != 4'hF) begin
                  row_idx   <= lowest_row(key_row);
                  pend_code <= key_map(lowest_row(key_row), col_idx);
                  cnt       <= '0;
                  state     <= DEBOUNCE;
               end else begin
                  col_idx <= col_idx + 2'd1;
                  key_col <= col_drive(col_idx + 2'd1);
               end
            end
            DEBOUNCE: begin
               if (key_row[row_idx]) begin
                  col_idx <= col_idx + 2'd1;
                  key_col <= col_drive(col_idx + 2'd1);
                  state   <= SCAN;
               end else if (cnt == CNT_LAST) begin
                  state <= PRESSED;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PRESSED: begin
               cnt   <= '0;
               state <= RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
               if (key_row != 4'hF) begin
                  cnt <= '0;
               end else if (cnt == CNT_LAST) begin
                  col_idx <= col_idx + 2'd1;
                  key_col <= col_drive(col_idx + 2'd1);
                  state   <= SCAN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

   keypad_bcd_editor u_editor (
      .clk_1k   (clk_1k),
      .resetn   (resetn),
      .stb      (edit_stb),
      .code     (pend_code),
      .sign     (sign),
      .hundreds (hundreds),
      .tens     (tens),
      .ones     (ones)
   );

endmodule
